// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers and the SATURATE mode encodings
// used by the Gray up/down counter slice.
package gray_pkg;

    localparam int MAX_W    = 32;
    localparam int SAT_WRAP = 0;
    localparam int SAT_HOLD = 1;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] r;
        r[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_prescaler.sv
// Clock-enable prescaler: emits one step_int every PRESCALE enabled cycles;
// a load clears the phase so counting restarts cleanly from the loaded value.
module gray_prescaler
    import gray_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic load,
    output logic step_int
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // With PRESCALE=1 LAST is 0, so pre stays 0 and every enabled cycle steps.
    always_comb begin
        pre_d    = pre_q;
        step_int = 1'b0;
        if (load) begin
            pre_d = '0;
        end else if (clk_en) begin
            if (pre_q == LAST) begin
                pre_d    = '0;
                step_int = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Parametrised N-bit Gray up/down counter with load, wrap/saturate modes,
// prescaled stepping and registered binary, step and terminal-count outputs.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int N        = 4,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         step,
    output logic         tc
);

    localparam logic [N-1:0] TOP    = '1;
    localparam logic [N-1:0] TOP_M1 = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] ONE    = N'(1);

    logic         step_int;
    logic [N-1:0] cnt_q,  cnt_d;
    logic [N-1:0] gray_q;
    logic         step_q, step_d;
    logic         tc_q,   tc_d;

    gray_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .load     (load),
        .step_int (step_int)
    );

    // Load beats a step; in saturate mode the limits hold, and tc marks
    // either a wrap or the arrival at a limit.
    always_comb begin
        cnt_d  = cnt_q;
        step_d = 1'b0;
        tc_d   = 1'b0;
        if (load) begin
            cnt_d = N'(gray2bin(MAX_W'(load_val)));
        end else if (step_int) begin
            step_d = 1'b1;
            if (up_dn) begin
                if (cnt_q == TOP) begin
                    if (SATURATE == SAT_WRAP) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    tc_d  = (SATURATE == SAT_HOLD) && (cnt_q == TOP_M1);
                end
            end else begin
                if (cnt_q == '0) begin
                    if (SATURATE == SAT_WRAP) begin
                        cnt_d = TOP;
                        tc_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                    tc_d  = (SATURATE == SAT_HOLD) && (cnt_q == ONE);
                end
            end
        end
    end

    // Both outputs are registered from the same next value so they never disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            step_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= N'(bin2gray(MAX_W'(cnt_d)));
            step_q <= step_d;
            tc_q   <= tc_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = cnt_q;
    assign step     = step_q;
    assign tc       = tc_q;

endmodule
